// File: rtl/i2c_reg_slave_pkg.sv
// Shared definitions for the register-mapped I2C slave: FSM states and bus constants.
package i2c_reg_slave_pkg;

  localparam int ADDR_W = 7;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_MACK,
    S_WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus stability filter for one I2C line; emits filtered level and edge pulses.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Bus idles high, so the synchroniser and filtered level reset to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        level <= sync[1];
        rise  <= sync[1];
        fall  <= ~sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_reg_slave.sv
// Register-mapped I2C slave: NREGS x 8 bank, auto-incrementing pointer, repeated START, host write port.
module i2c_reg_slave
  import i2c_reg_slave_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h42,
  parameter int                NREGS      = 8,
  parameter int                FILTER_LEN = 3,
  parameter logic [7:0]        RESET_VAL  = 8'h00,
  localparam int               PTR_W      = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scl_i,
  input  logic               sda_i,
  output logic               sda_oe,
  output logic [NREGS*8-1:0] regs_o,
  input  logic               hw_we,
  input  logic [PTR_W-1:0]   hw_addr,
  input  logic [7:0]         hw_data,
  output logic               wr_strobe,
  output logic [PTR_W-1:0]   wr_idx,
  output logic               hw_collide,
  output logic               busy
);

  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .reset(reset), .din(scl_i), .level(scl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .reset(reset), .din(sda_i), .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  state_t           state, state_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shift, shift_n, rx_byte;
  logic [PTR_W-1:0] ptr, ptr_n, ptr_inc;
  logic             sda_oe_n, busy_n, rw, rw_n, i2c_we;
  logic [7:0]       regs [NREGS];

  assign rx_byte = {shift[6:0], sda};
  assign ptr_inc = (ptr == PTR_W'(NREGS - 1)) ? '0 : ptr + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      rw      <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      ptr     <= ptr_n;
      sda_oe  <= sda_oe_n;
      busy    <= busy_n;
      rw      <= rw_n;
    end
  end

  // ACK states use bit_cnt as a phase flag: first SCL fall drives, second fall ends the ACK slot.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    ptr_n     = ptr;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    rw_n      = rw;
    i2c_we    = 1'b0;
    if (sda_rise && scl) begin
      state_n  = S_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (sda_fall && scl) begin
      state_n   = S_ADDR;
      bit_cnt_n = '0;
    end else begin
      unique case (state)
        S_IDLE, S_WAIT_STOP: ;
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_n   = rx_byte;
            bit_cnt_n = bit_cnt + 1'b1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              state_n   = S_WAIT_STOP;
              if (state == S_ADDR) begin
                rw_n = sda;
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_n = S_ADDR_ACK;
                  busy_n  = 1'b1;
                end
              end else if (state == S_PTR) begin
                if ({1'b0, rx_byte} < 9'(NREGS)) begin
                  ptr_n   = rx_byte[PTR_W-1:0];
                  state_n = S_PTR_ACK;
                end
              end else begin
                i2c_we  = 1'b1;
                ptr_n   = ptr_inc;
                state_n = S_WDATA_ACK;
              end
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_oe_n  = ~I2C_ACK;
              bit_cnt_n = 4'd1;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              if (state == S_ADDR_ACK && rw) begin
                state_n  = S_RDATA;
                shift_n  = regs[ptr];
                sda_oe_n = ~regs[ptr][7];
              end else if (state == S_ADDR_ACK) begin
                state_n = S_PTR;
              end else begin
                state_n = S_WDATA;
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 1'b1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n  = 1'b0;
              ptr_n     = ptr_inc;
              bit_cnt_n = '0;
              state_n   = S_RDATA_MACK;
            end else begin
              shift_n  = {shift[6:0], 1'b0};
              sda_oe_n = ~shift[6];
            end
          end
        end
        S_RDATA_MACK: begin
          if (scl_rise) begin
            if (sda == I2C_NACK) state_n = S_WAIT_STOP;
            else                 bit_cnt_n = 4'd1;
          end else if (scl_fall && bit_cnt == 4'd1) begin
            state_n   = S_RDATA;
            bit_cnt_n = '0;
            shift_n   = regs[ptr];
            sda_oe_n  = ~regs[ptr][7];
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // I2C write takes priority over a host write to the same register in the same clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
      wr_strobe  <= 1'b0;
      wr_idx     <= '0;
      hw_collide <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i2c_we && ptr == PTR_W'(i))        regs[i] <= rx_byte;
        else if (hw_we && hw_addr == PTR_W'(i)) regs[i] <= hw_data;
      end
      wr_strobe  <= i2c_we;
      if (i2c_we) wr_idx <= ptr;
      hw_collide <= i2c_we && hw_we && (hw_addr == ptr);
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_o[8*i +: 8] = regs[i];
  end

endmodule
